psx_mem_arbiter: RTL



---
 rtl/psx_mem_pkg.sv | 26 ++
 rtl/psx_mem_arbiter_if.sv | 45 ++++
 rtl/psx_mem_req_slot.sv | 53 +++++
 rtl/psx_mem_arbiter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/psx_mem_pkg.sv
// Shared types for the PSX memory arbiter.
// Holds the command-size codes, the arbiter FSM states and the per-port request record.
package psx_mem_pkg;

    localparam logic [1:0] CMD_8BYTE  = 2'd0;
    localparam logic [1:0] CMD_32BYTE = 2'd1;
    localparam logic [1:0] CMD_4BYTE  = 2'd2;

    typedef enum logic [2:0] {
        ARB_IDLE,
        ARB_CMD,
        ARB_GAP,
        ARB_WAIT_WR,
        ARB_WAIT_RD
    } arb_state_t;

    typedef struct packed {
        logic         writeElseRead;
        logic [1:0]   commandSize;
        logic [14:0]  targetAddr;
        logic [2:0]   subAddr;
        logic [15:0]  writeMask;
        logic [255:0] data;
    } mem_req_t;

endpackage

// File: rtl/psx_mem_arbiter_if.sv
// Client-side and bridge-side signal bundle of the PSX memory arbiter.
// The arbiter uses the slave view; clients and the bridge model use the master view.
interface psx_mem_arbiter_if #(
    parameter int N_PORTS = 3
);
    logic [N_PORTS-1:0]     i_command;
    logic [N_PORTS-1:0]     i_writeElseRead;
    logic [2*N_PORTS-1:0]   i_commandSize;
    logic [15*N_PORTS-1:0]  i_targetAddr;
    logic [3*N_PORTS-1:0]   i_subAddr;
    logic [16*N_PORTS-1:0]  i_writeMask;
    logic [256*N_PORTS-1:0] i_dataClient;
    logic [N_PORTS-1:0]     o_busyClient;
    logic [N_PORTS-1:0]     o_dataValidClient;
    logic [255:0]           o_dataClient;
    logic [N_PORTS-1:0]     o_overrun;

    logic                   o_command;
    logic                   o_writeElseRead;
    logic [1:0]             o_commandSize;
    logic [14:0]            o_targetAddr;
    logic [2:0]             o_subAddr;
    logic [15:0]            o_writeMask;
    logic [255:0]           o_dataBridge;
    logic                   i_busyBridge;
    logic                   i_dataValidBridge;
    logic [255:0]           i_dataBridge;

    modport slave (
        input  i_command, i_writeElseRead, i_commandSize, i_targetAddr, i_subAddr,
               i_writeMask, i_dataClient, i_busyBridge, i_dataValidBridge, i_dataBridge,
        output o_busyClient, o_dataValidClient, o_dataClient, o_overrun,
               o_command, o_writeElseRead, o_commandSize, o_targetAddr, o_subAddr,
               o_writeMask, o_dataBridge
    );

    modport master (
        output i_command, i_writeElseRead, i_commandSize, i_targetAddr, i_subAddr,
               i_writeMask, i_dataClient, i_busyBridge, i_dataValidBridge, i_dataBridge,
        input  o_busyClient, o_dataValidClient, o_dataClient, o_overrun,
               o_command, o_writeElseRead, o_commandSize, o_targetAddr, o_subAddr,
               o_writeMask, o_dataBridge
    );

endinterface

// File: rtl/psx_mem_req_slot.sv
// One requester's command slot: captures a pulse when empty, flags overrun when full.
// A command arriving in the same cycle as the release still sees the slot as full.
module psx_mem_req_slot
    import psx_mem_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_rst,
    input  logic     i_command,
    input  mem_req_t i_req,
    input  logic     i_release,
    output logic     o_valid,
    output mem_req_t o_req,
    output logic     o_overrun
);

    logic     valid_q, valid_d;
    logic     overrun_q, overrun_d;
    mem_req_t req_q, req_d;

    always_comb begin
        valid_d   = valid_q;
        overrun_d = overrun_q;
        req_d     = req_q;
        if (i_release) begin
            valid_d = 1'b0;
        end
        if (i_command) begin
            if (valid_q) begin
                overrun_d = 1'b1;
            end else begin
                req_d   = i_req;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            req_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            req_q     <= req_d;
        end
    end

    assign o_valid   = valid_q;
    assign o_req     = req_q;
    assign o_overrun = overrun_q;

endmodule

// File: rtl/psx_mem_arbiter.sv
// Shares the single DDR bridge command port between N_PORTS requesters.
// One slot per port; a five-state FSM grants the bridge and steers read data back.
module psx_mem_arbiter
    import psx_mem_pkg::*;
#(
    parameter int N_PORTS     = 3,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    psx_mem_arbiter_if.slave  bus
);

    localparam int IDX_W = (N_PORTS > 2) ? 2 : 1;

    arb_state_t         state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   lastGrant_q, lastGrant_d;

    logic [N_PORTS-1:0] slotValid;
    logic [N_PORTS-1:0] slotOverrun;
    logic [N_PORTS-1:0] releaseSlot;
    logic [N_PORTS-1:0] dataValidClient;
    mem_req_t           slotReq [N_PORTS];
    mem_req_t           ownerReq;

    logic               haveWinner;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   candSel;
    int                 candIdx;
    logic               cmdOut;

    for (genvar k = 0; k < N_PORTS; k++) begin : g_slot
        mem_req_t loadReq;

        assign loadReq = '{
            writeElseRead: bus.i_writeElseRead[k],
            commandSize:   bus.i_commandSize[2*k +: 2],
            targetAddr:    bus.i_targetAddr[15*k +: 15],
            subAddr:       bus.i_subAddr[3*k +: 3],
            writeMask:     bus.i_writeMask[16*k +: 16],
            data:          bus.i_dataClient[256*k +: 256]
        };

        psx_mem_req_slot u_slot (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_command (bus.i_command[k]),
            .i_req     (loadReq),
            .i_release (releaseSlot[k]),
            .o_valid   (slotValid[k]),
            .o_req     (slotReq[k]),
            .o_overrun (slotOverrun[k])
        );
    end

    // Round-robin scans from lastGrant+1 with wrap; fixed priority scans from port 0.
    always_comb begin
        haveWinner = 1'b0;
        winner     = '0;
        candIdx    = 0;
        candSel    = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            candIdx = ROUND_ROBIN ? (int'(lastGrant_q) + 1 + i) : i;
            if (candIdx >= N_PORTS) begin
                candIdx = candIdx - N_PORTS;
            end
            candSel = IDX_W'(candIdx);
            if (!haveWinner && slotValid[candSel]) begin
                haveWinner = 1'b1;
                winner     = candSel;
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        lastGrant_d     = lastGrant_q;
        releaseSlot     = '0;
        dataValidClient = '0;
        cmdOut          = 1'b0;
        ownerReq        = slotReq[owner_q];
        case (state_q)
            ARB_IDLE: begin
                if (haveWinner && !bus.i_busyBridge) begin
                    owner_d = winner;
                    state_d = ARB_CMD;
                end
            end
            ARB_CMD: begin
                cmdOut      = 1'b1;
                lastGrant_d = owner_q;
                state_d     = ARB_GAP;
            end
            ARB_GAP: begin
                state_d = ownerReq.writeElseRead ? ARB_WAIT_WR : ARB_WAIT_RD;
            end
            ARB_WAIT_WR: begin
                if (!bus.i_busyBridge) begin
                    releaseSlot[owner_q] = 1'b1;
                    state_d              = ARB_IDLE;
                end
            end
            // Only the data strobe ends a read; a low busy flag alone is not enough.
            ARB_WAIT_RD: begin
                if (bus.i_dataValidBridge) begin
                    releaseSlot[owner_q]     = 1'b1;
                    dataValidClient[owner_q] = 1'b1;
                    state_d                  = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ARB_IDLE;
            owner_q     <= '0;
            lastGrant_q <= IDX_W'(N_PORTS - 1);
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            lastGrant_q <= lastGrant_d;
        end
    end

    assign bus.o_busyClient      = slotValid;
    assign bus.o_overrun         = slotOverrun;
    assign bus.o_dataValidClient = dataValidClient;
    assign bus.o_dataClient      = bus.i_dataBridge;

    assign bus.o_command         = cmdOut;
    assign bus.o_writeElseRead   = ownerReq.writeElseRead;
    assign bus.o_commandSize     = ownerReq.commandSize;
    assign bus.o_targetAddr      = ownerReq.targetAddr;
    assign bus.o_subAddr         = ownerReq.subAddr;
    assign bus.o_writeMask       = ownerReq.writeMask;
    assign bus.o_dataBridge      = ownerReq.data;

endmodule
